// File: rtl/store_commit_queue_pkg.sv
// Shared types for the store commit queue: entry payload and drain FSM states.
package store_commit_queue_pkg;

  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int BE_W = XLEN / 8;

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BE_W-1:0] be;
    logic [1:0]      size;
  } store_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } st_drain_state_e;

endpackage

// File: rtl/store_commit_queue_if.sv
// Bundle of LSU, commit_stage and D$ write-port signals seen by the store commit queue.
`default_nettype none
interface store_commit_queue_if;
  import store_commit_queue_pkg::*;

  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [PLEN-1:0] paddr_i;
  logic [XLEN-1:0] data_i;
  logic [BE_W-1:0] be_i;
  logic [1:0]      size_i;
  logic            commit_i;
  logic            commit_ready_o;
  logic            no_st_pending_o;
  logic [11:0]     page_offset_i;
  logic            page_offset_matches_o;
  logic            req_o;
  logic [PLEN-1:0] req_paddr_o;
  logic [XLEN-1:0] req_data_o;
  logic [BE_W-1:0] req_be_o;
  logic [1:0]      req_size_o;
  logic            gnt_i;
  logic            ack_i;

  modport slave (
    input  flush_i, valid_i, paddr_i, data_i, be_i, size_i, commit_i,
           page_offset_i, gnt_i, ack_i,
    output ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o,
           req_o, req_paddr_o, req_data_o, req_be_o, req_size_o
  );

  modport master (
    output flush_i, valid_i, paddr_i, data_i, be_i, size_i, commit_i,
           page_offset_i, gnt_i, ack_i,
    input  ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o,
           req_o, req_paddr_o, req_data_o, req_be_o, req_size_o
  );

endinterface
`default_nettype wire

// File: rtl/store_commit_queue_entry_fifo.sv
// Circular FIFO of store entries; exposes every slot plus a valid mask for address compares.
`default_nettype none
module store_entry_fifo
  import store_commit_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  store_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output store_entry_t           head,
  output store_entry_t           entries [DEPTH],
  output logic [DEPTH-1:0]       valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  store_entry_t  mem [DEPTH];

  // Flush drops everything, including anything pushed or popped in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[i];
      valid[i]   = {1'b0, AW'(i) - rd_ptr} < count;
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/store_commit_queue.sv
// Speculative + committed store buffers with a one-at-a-time req/gnt/ack drain to the D$.
`default_nettype none
module store_commit_queue
  import store_commit_queue_pkg::*;
#(
  parameter int SPEC_DEPTH   = 4,
  parameter int COMMIT_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  store_commit_queue_if.slave  bus
);

  localparam int SW = $clog2(SPEC_DEPTH) + 1;
  localparam int CW = $clog2(COMMIT_DEPTH) + 1;

  logic [SW-1:0]   spec_count;
  logic [CW-1:0]   com_count;
  store_entry_t    spec_head;
  store_entry_t    com_head;
  store_entry_t    spec_entries [SPEC_DEPTH];
  store_entry_t    com_entries  [COMMIT_DEPTH];
  logic [SPEC_DEPTH-1:0]   spec_valid;
  logic [COMMIT_DEPTH-1:0] com_valid;
  store_entry_t    new_entry;
  logic            spec_push;
  logic            commit_fire;
  logic            drain_pop;
  logic            entries_left;
  st_drain_state_e state;
  st_drain_state_e state_next;

  assign bus.ready_o        = spec_count != SW'(SPEC_DEPTH);
  assign bus.commit_ready_o = com_count != CW'(COMMIT_DEPTH);

  assign new_entry   = '{paddr: bus.paddr_i, data: bus.data_i, be: bus.be_i, size: bus.size_i};
  assign spec_push   = bus.valid_i && bus.ready_o && !bus.flush_i;
  assign commit_fire = bus.commit_i && (spec_count != '0) && bus.commit_ready_o;

  store_entry_fifo #(.DEPTH(SPEC_DEPTH)) u_spec_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (spec_push),
    .push_data (new_entry),
    .pop       (commit_fire),
    .flush     (bus.flush_i),
    .count     (spec_count),
    .head      (spec_head),
    .entries   (spec_entries),
    .valid     (spec_valid)
  );

  store_entry_fifo #(.DEPTH(COMMIT_DEPTH)) u_commit_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (commit_fire),
    .push_data (spec_head),
    .pop       (drain_pop),
    .flush     (1'b0),
    .count     (com_count),
    .head      (com_head),
    .entries   (com_entries),
    .valid     (com_valid)
  );

  // Whether the committed queue still holds something once the current head pops.
  assign entries_left = (com_count > CW'(1)) || commit_fire;

  always_comb begin
    state_next = state;
    drain_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (com_count != '0 || commit_fire) state_next = REQ;
      end
      REQ: begin
        if (bus.gnt_i) begin
          if (bus.ack_i) begin
            drain_pop  = 1'b1;
            state_next = entries_left ? REQ : IDLE;
          end else begin
            state_next = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.ack_i) begin
          drain_pop  = 1'b1;
          state_next = entries_left ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  assign bus.req_o           = state == REQ;
  assign bus.req_paddr_o     = bus.req_o ? com_head.paddr : '0;
  assign bus.req_data_o      = bus.req_o ? com_head.data  : '0;
  assign bus.req_be_o        = bus.req_o ? com_head.be    : '0;
  assign bus.req_size_o      = bus.req_o ? com_head.size  : '0;
  // Speculative stores are excluded so a fence waiting on this cannot deadlock commit.
  assign bus.no_st_pending_o = (com_count == '0) && (state == IDLE);

  always_comb begin
    bus.page_offset_matches_o = 1'b0;
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      if (spec_valid[i] && spec_entries[i].paddr[11:3] == bus.page_offset_i[11:3])
        bus.page_offset_matches_o = 1'b1;
    end
    for (int i = 0; i < COMMIT_DEPTH; i++) begin
      if (com_valid[i] && com_entries[i].paddr[11:3] == bus.page_offset_i[11:3])
        bus.page_offset_matches_o = 1'b1;
    end
  end

  a_commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.commit_i |-> (spec_count != '0 && bus.commit_ready_o));

  a_ack_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.ack_i |-> (state == WAIT_ACK || (state == REQ && bus.gnt_i)));

endmodule
`default_nettype wire
